// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Multicycle control FSM for a MIPS datapath. Emits one control
//            word per cycle to sequence the PC register, the memory port,
//            the IR, the register file and the ALU.
// Revision : 1.0 - initial release
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   op           opcode field IR[31:26]; sampled only in DECODE
//   mem_ready    memory completes current access (used only with
//                MC_MEM_WAIT_EN)
//   PCWrite, PCWriteCond, PCSource      PC register control
//   IorD, MemRead, MemWrite, IRWrite    memory / IR control
//   RegDst, MemtoReg, RegWrite          register-file control
//   ALUSrcA, ALUSrcB, ALUOp             ALU control
//   state        current state, for debug
//   illegal_op   high during a DECODE cycle holding an unknown opcode
//
// Configuration
//   MC_MEM_WAIT_EN  when defined, FETCH/MEMRD/MEMWR stall while mem_ready=0
//                   and IRWrite/PCWrite in FETCH are gated by mem_ready.
// ============================================================================
module mc_ctrl #(
  parameter int OP_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic [1:0]      PCSource,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            RegDst,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [3:0]      state,
  output logic            illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_JUMP_EX  = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);

  state_t cur_state;
  // op is only valid in DECODE, so the lw/sw split taken in MEMADR is
  // remembered here rather than re-read from op.
  logic   is_store;
  logic   mem_done;
  logic   op_legal;

`ifdef MC_MEM_WAIT_EN
  assign mem_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done         = 1'b1;
`endif

  assign state = cur_state;

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= S_FETCH;
      is_store  <= 1'b0;
    end else begin
      case (cur_state)
        S_FETCH: begin
          if (mem_done) cur_state <= S_DECODE;
        end
        S_DECODE: begin
          case (op)
            OP_LW: begin
              cur_state <= S_MEMADR;
              is_store  <= 1'b0;
            end
            OP_SW: begin
              cur_state <= S_MEMADR;
              is_store  <= 1'b1;
            end
            OP_RTYPE: cur_state <= S_RTYPE_EX;
            OP_BEQ:   cur_state <= S_BEQ_EX;
            OP_J:     cur_state <= S_JUMP_EX;
            OP_ADDI:  cur_state <= S_ADDI_EX;
            default:  cur_state <= S_FETCH;
          endcase
        end
        S_MEMADR:   cur_state <= is_store ? S_MEMWR : S_MEMRD;
        S_MEMRD: begin
          if (mem_done) cur_state <= S_MEMWB;
        end
        S_MEMWR: begin
          if (mem_done) cur_state <= S_FETCH;
        end
        S_RTYPE_EX: cur_state <= S_RTYPE_WB;
        S_ADDI_EX:  cur_state <= S_ADDI_WB;
        S_MEMWB, S_RTYPE_WB, S_BEQ_EX, S_JUMP_EX, S_ADDI_WB:
                    cur_state <= S_FETCH;
        default:    cur_state <= S_FETCH;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Control word. Decoded from the state so it is valid in the same cycle;
  // gated by rst so the whole word (including FETCH) drops to zero as soon
  // as reset asserts, without waiting for a clock edge.
  // --------------------------------------------------------------------------
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    illegal_op  = 1'b0;
    if (rst) begin
      case (cur_state)
        S_FETCH: begin
          MemRead = 1'b1;
          // IR and PC update only in the cycle the fetch actually completes.
          IRWrite = mem_done;
          PCWrite = mem_done;
          ALUSrcB = 2'b01;
        end
        S_DECODE: begin
          ALUSrcB    = 2'b11;
          illegal_op = ~op_legal;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_RTYPE_EX: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_RTYPE_WB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BEQ_EX: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_JUMP_EX: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_ADDI_EX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_ADDI_WB: begin
          RegWrite = 1'b1;
        end
        default: begin
          PCWrite = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle control FSM for the MIPS datapath. It sequences the PC register, the instruction/data memory port, the IR, the register file and the ALU by emitting one control word per cycle. Its PC-control outputs drive the PC register's `PCWrite`, `PCWriteCond` and `PCSource` inputs directly. The PC register gives `PCWriteCond & zero` priority over `PCWrite` and selects `ALUOut` in that case.

## Interface
- `OP_W`, default 6: opcode width.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `op` input OP_W: IR[31:26], valid from DECODE onward.
- `mem_ready` input 1: memory completes the current access this cycle. Used only with `MC_MEM_WAIT_EN`.
- `PCWrite`, `PCWriteCond` output 1 each: to the PC register.
- `PCSource` output 2: 00 = ALU result (PC+4), 01 = branch (ALUOut path), 10 = jump.
- `IorD`, `MemRead`, `MemWrite`, `IRWrite` output 1 each: memory and IR control.
- `RegDst`, `MemtoReg`, `RegWrite` output 1 each: register-file control.
- `ALUSrcA` output 1; `ALUSrcB` output 2; `ALUOp` output 2: ALU control.
- `state` output 4: current state, for debug.
- `illegal_op` output 1: one-cycle pulse in DECODE on an unknown opcode.

## Operation
- **State encoding:** FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPE_EX=6, RTYPE_WB=7, BEQ_EX=8, JUMP_EX=9, ADDI_EX=10, ADDI_WB=11. Codes 12-15 are unreachable and return to FETCH.
- **Opcodes:** R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
- **Transitions:**
  - FETCH→DECODE.
  - DECODE→MEMADR on lw/sw, RTYPE_EX on R, BEQ_EX on beq, JUMP_EX on j, ADDI_EX on addi. Any other opcode goes to FETCH and pulses `illegal_op`.
  - MEMADR→MEMRD on lw, MEMWR on sw.
  - MEMRD→MEMWB.
  - RTYPE_EX→RTYPE_WB.
  - ADDI_EX→ADDI_WB.
  - MEMWB, MEMWR, RTYPE_WB, BEQ_EX, JUMP_EX and ADDI_WB all go to FETCH.
- **Control words:** outputs are Moore-decoded from `state`. Every signal not listed below is 0.
  - FETCH: MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
  - DECODE: ALUSrcB=11 (branch target computed into ALUOut).
  - MEMADR: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1.
  - MEMWR: MemWrite=1, IorD=1.
  - RTYPE_EX: ALUSrcA=1, ALUOp=10.
  - RTYPE_WB: RegWrite=1, RegDst=1.
  - BEQ_EX: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP_EX: PCWrite=1, PCSource=10.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=10.
  - ADDI_WB: RegWrite=1.
- **Invariants:**
  - `PCWrite` and `PCWriteCond` are never both 1.
  - `MemRead` and `MemWrite` are never both 1.
- **Reset:** while `rst`=0, `state`=FETCH and all outputs are forced to 0, including the FETCH word. Reset asserted mid-instruction abandons that instruction immediately. Normal sequencing resumes on the first rising edge after release, starting from FETCH.

## Timing
- **Cycles per instruction, without wait states:** lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- The state register updates on the rising edge of `clk`. Outputs are valid combinationally within the same cycle as the state.
- `op` is sampled only in DECODE. The IR was written at the end of FETCH.
- The PC register samples `PCWrite`/`PCWriteCond`/`PCSource` on the edge that leaves FETCH, BEQ_EX or JUMP_EX.
- `illegal_op` is high only during the DECODE cycle that holds an illegal opcode.

## Configuration
- **Macro:** `MC_MEM_WAIT_EN`.
- **With the macro defined:**
  - FETCH, MEMRD and MEMWR hold their state while `mem_ready`=0, keeping MemRead/MemWrite/IorD asserted.
  - In FETCH, `IRWrite` and `PCWrite` are gated by `mem_ready`, so they assert only in the completing cycle. This makes them Mealy outputs.
  - MEMWB is entered only after `mem_ready`=1 in MEMRD.
  - Each wait cycle adds exactly one cycle to the latency.
- **Without the macro:** `mem_ready` is ignored (the port remains) and every state lasts exactly one cycle.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles → `state`=0 and all outputs 0. Release → cycle 1 shows MemRead=IRWrite=PCWrite=1, ALUSrcB=01, PCSource=00.
- **lw then sw:** `op`=100011 → states 0,1,2,3,4. MEMWB shows RegWrite=1, MemtoReg=1, RegDst=0. Then `op`=101011 → states 0,1,2,5 with MemWrite=1, IorD=1.
- **R-type and addi:** `op`=000000 → RTYPE_EX ALUOp=10, RTYPE_WB RegDst=1. `op`=001000 → ADDI_EX ALUSrcB=10, ADDI_WB RegWrite=1, RegDst=0. Each takes 4 cycles.
- **beq / j:** `op`=000100 → state 8 with PCWriteCond=1, ALUOp=01, PCWrite=0, then FETCH. `op`=000010 → state 9 with PCWrite=1, PCSource=10, then FETCH. Each takes 3 cycles.
- **Illegal opcode and mid-reset:** `op`=111111 → `illegal_op` pulses for one cycle in DECODE, next state FETCH. Assert `rst`=0 in MEMRD → outputs go to 0 asynchronously, `state`=0.
- **`MC_MEM_WAIT_EN`:** `mem_ready`=0 for 2 cycles in FETCH → state stays 0 and IRWrite=PCWrite=0. Third cycle `mem_ready`=1 → IRWrite=PCWrite=1, then DECODE. lw total is 7 cycles.
